// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the register-file write arbiter.
package cpu_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int LL_WIDTH = 32;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [LL_WIDTH-1:0]   data;
    } ll_entry_t;
    typedef enum logic {NORMAL, STARVE} arb_state_t;
endpackage

// File: rtl/ll_result_fifo.sv
// ll_result_fifo: synchronous FIFO buffering long-latency results until the write port is free.
module ll_result_fifo import cpu_pkg::*; #(
    parameter int DEPTH = 2,
    parameter type entry_t = ll_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output entry_t head,
    output logic   full,
    output logic   empty
);
    localparam int AW = $clog2(DEPTH);
    entry_t mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] cnt;
    assign head = mem[rptr];
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    always_ff @(posedge clk)
        if (push) mem[wptr] <= din;
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt <= '0;
        end else begin
            wptr <= push ? wptr + AW'(1) : wptr;
            rptr <= pop ? rptr + AW'(1) : rptr;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between W-stage writeback and
// buffered long-latency results, with a pending scoreboard and starvation stall.
module regfile_write_arbiter import cpu_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteW,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic [WIDTH-1:0]      ResultW,
    input  logic                  LLIssue,
    input  logic [REG_ADDR_W-1:0] LLIssueRd,
    output logic                  LLIssueOK,
    input  logic                  LLValid,
    input  logic [REG_ADDR_W-1:0] LLRd,
    input  logic [WIDTH-1:0]      LLData,
    output logic                  LLReady,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic                  RegWriteD,
    output logic                  HazardD,
    output logic                  StarveStall,
    output logic                  WE3,
    output logic [REG_ADDR_W-1:0] A3,
    output logic [WIDTH-1:0]      WD3
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WIDTH-1:0]      data;
    } entry_t;
    entry_t head;
    logic full, empty, pipe_wr, push, pop, inc, dec, blocked;
    logic [CW-1:0] ocnt;
    logic [SW-1:0] scnt;
    logic [31:0] pending, set_mask, clr_mask;
    arb_state_t state;
    ll_result_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop),
        .din('{rd: LLRd, data: LLData}), .head(head), .full(full), .empty(empty)
    );
    assign pipe_wr = RegWriteW && RdW != '0;
    assign pop = !pipe_wr && !empty;
    assign blocked = pipe_wr && !empty;
    assign LLReady = !full;
    assign push = LLValid && !full && LLRd != '0;
    assign LLIssueOK = ocnt < CW'(FIFO_DEPTH) && !pending[LLIssueRd];
    assign inc = LLIssue && LLIssueOK && LLIssueRd != '0;
    // results pushed without a tracked issue must not underflow the count
    assign dec = pop && ocnt != '0;
    assign set_mask = inc ? 32'(1) << LLIssueRd : '0;
    assign clr_mask = pop ? 32'(1) << head.rd : '0;
    assign HazardD = pending[Rs1D] | pending[Rs2D] | (RegWriteD & pending[RdD]);
    assign StarveStall = state == STARVE;
    assign WE3 = pipe_wr || !empty;
    assign A3 = pipe_wr ? RdW : (!empty ? head.rd : '0);
    assign WD3 = pipe_wr ? ResultW : (!empty ? head.data : '0);
    always_ff @(posedge clk) begin
        if (rst) begin
            ocnt <= '0;
            scnt <= '0;
            pending <= '0;
            state <= NORMAL;
        end else begin
            ocnt <= ocnt + CW'(inc) - CW'(dec);
            pending <= ((pending & ~clr_mask) | set_mask) & ~32'd1;
            scnt <= blocked ? (scnt == SW'(STARVE_LIMIT - 1) ? scnt : scnt + SW'(1)) : '0;
            state <= pop ? NORMAL
                   : (blocked && scnt == SW'(STARVE_LIMIT - 1)) ? STARVE : state;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed scenario tasks with hand-computed expectations.
module tb_regfile_write_arbiter;
    logic clk = 0, rst = 0;
    logic RegWriteW, LLIssue, LLIssueOK, LLValid, LLReady, RegWriteD, HazardD, StarveStall, WE3;
    logic [4:0] RdW, LLIssueRd, LLRd, Rs1D, Rs2D, RdD, A3;
    logic [31:0] ResultW, LLData, WD3;
    int n_cmp = 0, n_bad = 0;

    regfile_write_arbiter dut (
        .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .LLIssue(LLIssue), .LLIssueRd(LLIssueRd), .LLIssueOK(LLIssueOK),
        .LLValid(LLValid), .LLRd(LLRd), .LLData(LLData), .LLReady(LLReady),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD), .HazardD(HazardD),
        .StarveStall(StarveStall), .WE3(WE3), .A3(A3), .WD3(WD3)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        RegWriteW = 0; RdW = 0; ResultW = 0;
        LLIssue = 0; LLIssueRd = 0;
        LLValid = 0; LLRd = 0; LLData = 0;
        Rs1D = 0; Rs2D = 0; RdD = 0; RegWriteD = 0;
    endtask

    task automatic test_reset;
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
        #1;
        n_cmp++; if (LLReady !== 1'b1) begin n_bad++; $display("FAIL reset_llready got %b want 1", LLReady); end
        n_cmp++; if (LLIssueOK !== 1'b1) begin n_bad++; $display("FAIL reset_issueok got %b want 1", LLIssueOK); end
        n_cmp++; if (HazardD !== 1'b0) begin n_bad++; $display("FAIL reset_hazard got %b want 0", HazardD); end
        n_cmp++; if (StarveStall !== 1'b0) begin n_bad++; $display("FAIL reset_starve got %b want 0", StarveStall); end
        n_cmp++; if ({WE3, A3, WD3} !== 38'd0) begin n_bad++; $display("FAIL reset_port got we=%b a=%0d d=%h want 0", WE3, A3, WD3); end
    endtask

    task automatic test_basic_ll;
        LLIssue = 1; LLIssueRd = 5;
        #1;
        n_cmp++; if (LLIssueOK !== 1'b1) begin n_bad++; $display("FAIL basic_issueok got %b want 1", LLIssueOK); end
        tick();
        LLIssue = 0; Rs1D = 5;
        #1;
        n_cmp++; if (HazardD !== 1'b1) begin n_bad++; $display("FAIL basic_hazard_pending got %b want 1", HazardD); end
        LLValid = 1; LLRd = 5; LLData = 32'hDEADBEEF;
        #1;
        n_cmp++; if (WE3 !== 1'b0) begin n_bad++; $display("FAIL basic_no_early_write got %b want 0", WE3); end
        tick();
        LLValid = 0;
        #1;
        n_cmp++; if ({WE3, A3, WD3} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin n_bad++; $display("FAIL basic_drain got we=%b a=%0d d=%h want 1/5/deadbeef", WE3, A3, WD3); end
        n_cmp++; if (HazardD !== 1'b1) begin n_bad++; $display("FAIL basic_hazard_at_drain got %b want 1", HazardD); end
        tick();
        n_cmp++; if (HazardD !== 1'b0) begin n_bad++; $display("FAIL basic_hazard_cleared got %b want 0", HazardD); end
        n_cmp++; if (WE3 !== 1'b0) begin n_bad++; $display("FAIL basic_idle_after got %b want 0", WE3); end
        idle();
    endtask

    task automatic test_starvation;
        RegWriteW = 1; RdW = 3; ResultW = 32'h33;
        LLValid = 1; LLRd = 7; LLData = 32'h77;
        #1;
        n_cmp++; if (A3 !== 5'd3) begin n_bad++; $display("FAIL starve_push_a3 got %0d want 3", A3); end
        tick();
        LLValid = 0;
        for (int i = 1; i <= 5; i++) begin
            #1;
            n_cmp++; if ({WE3, A3, WD3} !== {1'b1, 5'd3, 32'h33}) begin n_bad++; $display("FAIL starve_pipe_wins_%0d got we=%b a=%0d d=%h want 1/3/33", i, WE3, A3, WD3); end
            n_cmp++; if (StarveStall !== (i >= 5)) begin n_bad++; $display("FAIL starve_stall_%0d got %b want %b", i, StarveStall, i >= 5); end
            tick();
        end
        RegWriteW = 0;
        #1;
        n_cmp++; if ({WE3, A3, WD3} !== {1'b1, 5'd7, 32'h77}) begin n_bad++; $display("FAIL starve_drain got we=%b a=%0d d=%h want 1/7/77", WE3, A3, WD3); end
        n_cmp++; if (StarveStall !== 1'b1) begin n_bad++; $display("FAIL starve_hold_at_drain got %b want 1", StarveStall); end
        tick();
        n_cmp++; if (StarveStall !== 1'b0) begin n_bad++; $display("FAIL starve_release got %b want 0", StarveStall); end
        n_cmp++; if (WE3 !== 1'b0) begin n_bad++; $display("FAIL starve_idle got %b want 0", WE3); end
        idle();
    endtask

    task automatic test_back_to_back;
        LLIssue = 1; LLIssueRd = 8;
        tick();
        LLIssueRd = 9;
        tick();
        LLIssueRd = 11;
        #1;
        n_cmp++; if (LLIssueOK !== 1'b0) begin n_bad++; $display("FAIL b2b_issue_blocked got %b want 0", LLIssueOK); end
        RegWriteW = 1; RdW = 1; ResultW = 32'h11;
        LLValid = 1; LLRd = 8; LLData = 32'h88;
        tick();
        LLIssue = 0; LLRd = 9; LLData = 32'h99;
        #1;
        n_cmp++; if (LLReady !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_one got %b want 1", LLReady); end
        tick();
        LLValid = 0;
        #1;
        n_cmp++; if (LLReady !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_full got %b want 0", LLReady); end
        n_cmp++; if (A3 !== 5'd1) begin n_bad++; $display("FAIL b2b_pipe_a3 got %0d want 1", A3); end
        RegWriteW = 0;
        #1;
        n_cmp++; if ({WE3, A3, WD3} !== {1'b1, 5'd8, 32'h88}) begin n_bad++; $display("FAIL b2b_first got we=%b a=%0d d=%h want 1/8/88", WE3, A3, WD3); end
        tick();
        Rs1D = 11;
        #1;
        n_cmp++; if ({WE3, A3, WD3} !== {1'b1, 5'd9, 32'h99}) begin n_bad++; $display("FAIL b2b_second got we=%b a=%0d d=%h want 1/9/99", WE3, A3, WD3); end
        n_cmp++; if (LLReady !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after got %b want 1", LLReady); end
        n_cmp++; if (HazardD !== 1'b0) begin n_bad++; $display("FAIL b2b_ignored_issue got %b want 0", HazardD); end
        tick();
        n_cmp++; if (WE3 !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got %b want 0", WE3); end
        n_cmp++; if (StarveStall !== 1'b0) begin n_bad++; $display("FAIL b2b_no_starve got %b want 0", StarveStall); end
        idle();
    endtask

    task automatic test_rd_zero;
        LLValid = 1; LLRd = 4; LLData = 32'h44;
        tick();
        LLValid = 0;
        RegWriteW = 1; RdW = 0; ResultW = 32'h1234;
        #1;
        n_cmp++; if ({WE3, A3, WD3} !== {1'b1, 5'd4, 32'h44}) begin n_bad++; $display("FAIL rd0_ll_wins got we=%b a=%0d d=%h want 1/4/44", WE3, A3, WD3); end
        tick();
        RegWriteW = 0;
        LLValid = 1; LLRd = 0; LLData = 32'h55;
        #1;
        n_cmp++; if (WE3 !== 1'b0) begin n_bad++; $display("FAIL rd0_push_cycle got %b want 0", WE3); end
        tick();
        LLValid = 0;
        #1;
        n_cmp++; if ({WE3, A3, WD3} !== 38'd0) begin n_bad++; $display("FAIL rd0_dropped got we=%b a=%0d d=%h want 0", WE3, A3, WD3); end
        idle();
    endtask

    task automatic test_same_cycle_set_clear;
        LLValid = 1; LLRd = 10; LLData = 32'hA0;
        tick();
        LLValid = 0;
        LLIssue = 1; LLIssueRd = 10;
        #1;
        n_cmp++; if (LLIssueOK !== 1'b1) begin n_bad++; $display("FAIL sc_issueok got %b want 1", LLIssueOK); end
        n_cmp++; if ({WE3, A3, WD3} !== {1'b1, 5'd10, 32'hA0}) begin n_bad++; $display("FAIL sc_drain got we=%b a=%0d d=%h want 1/10/a0", WE3, A3, WD3); end
        tick();
        LLIssue = 0; Rs2D = 10;
        #1;
        n_cmp++; if (HazardD !== 1'b1) begin n_bad++; $display("FAIL sc_set_wins got %b want 1", HazardD); end
        LLValid = 1; LLRd = 10; LLData = 32'hA1;
        tick();
        LLValid = 0;
        tick();
        n_cmp++; if (HazardD !== 1'b0) begin n_bad++; $display("FAIL sc_cleanup got %b want 0", HazardD); end
        idle();
    endtask

    task automatic test_reset_midop;
        LLIssue = 1; LLIssueRd = 12;
        tick();
        LLIssueRd = 13;
        tick();
        LLIssue = 0;
        RegWriteW = 1; RdW = 2; ResultW = 32'h22;
        LLValid = 1; LLRd = 12; LLData = 32'hC0;
        tick();
        LLRd = 13; LLData = 32'hD0;
        tick();
        LLValid = 0; Rs1D = 12; Rs2D = 13;
        #1;
        n_cmp++; if (LLReady !== 1'b0) begin n_bad++; $display("FAIL rst_full_before got %b want 0", LLReady); end
        n_cmp++; if (HazardD !== 1'b1) begin n_bad++; $display("FAIL rst_pending_before got %b want 1", HazardD); end
        rst = 1; RegWriteW = 0;
        tick();
        rst = 0;
        #1;
        n_cmp++; if (WE3 !== 1'b0) begin n_bad++; $display("FAIL rst_we3 got %b want 0", WE3); end
        n_cmp++; if (LLReady !== 1'b1) begin n_bad++; $display("FAIL rst_llready got %b want 1", LLReady); end
        n_cmp++; if (HazardD !== 1'b0) begin n_bad++; $display("FAIL rst_hazard got %b want 0", HazardD); end
        n_cmp++; if (StarveStall !== 1'b0) begin n_bad++; $display("FAIL rst_starve got %b want 0", StarveStall); end
        tick();
        n_cmp++; if (WE3 !== 1'b0) begin n_bad++; $display("FAIL rst_no_stale got %b want 0", WE3); end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_basic_ll();
        test_starvation();
        test_back_to_back();
        test_rd_zero();
        test_same_cycle_set_clear();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback (W stage) and a multi-cycle long-latency unit (LL: mul/div).
- Buffers LL results in a 2-entry FIFO and tracks LL destinations in a 32-entry pending scoreboard.
- Raises a decode hazard and a starvation stall to the hazard unit.
- Sits between the W stage, the LL unit, the register file write port (WE3/A3/WD3) and the hazard unit.

Parameters:
- WIDTH, 32, data width of results and the write port.
- FIFO_DEPTH, 2, LL result buffer entries (power of two, ≥2).
- STARVE_LIMIT, 4, cycles an LL result may wait at the FIFO head before a stall is forced.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- RegWriteW  in  1  pipeline writeback enable
- RdW  in  5  pipeline writeback destination
- ResultW  in  WIDTH  pipeline writeback data
- LLIssue  in  1  LL op issued this cycle (from E stage)
- LLIssueRd  in  5  destination of the issued LL op
- LLIssueOK  out  1  LL issue permitted this cycle
- LLValid  in  1  LL result available
- LLRd  in  5  LL result destination
- LLData  in  WIDTH  LL result data
- LLReady  out  1  FIFO can accept an LL result
- Rs1D, Rs2D, RdD  in  5 each  decode-stage register fields
- RegWriteD  in  1  decode-stage write enable
- HazardD  out  1  decode must stall on a pending LL destination
- StarveStall  out  1  freeze F..M and bubble W next cycle
- WE3  out  1  register-file write enable
- A3  out  5  register-file write address
- WD3  out  WIDTH  register-file write data

Behaviour:
- Reset: FIFO empty, scoreboard all 0, outstanding count 0, starvation counter 0, FSM in NORMAL. Resulting outputs: LLReady=1, LLIssueOK=1, HazardD=0, StarveStall=0, WE3=0. Reset mid-operation discards buffered results and pending bits with no write.
- Write port (combinational):
  - pipe_wr = RegWriteW && RdW!=0; the pipeline always wins.
  - If pipe_wr: WE3=1, A3=RdW, WD3=ResultW.
  - Else if FIFO not empty: drain the head (WE3=1, A3=head.rd, WD3=head.data); the pop occurs at this clock edge.
  - Else WE3=0, A3=0, WD3=0.
- FIFO:
  - LLReady = !full. A push occurs on LLValid && LLReady.
  - Push and pop in the same cycle are both legal, and the count is unchanged.
  - LLValid with LLRd==0 is accepted and dropped: no push, and no scoreboard change.
- Outstanding count:
  - Range 0..FIFO_DEPTH.
  - +1 on an accepted LLIssue with LLIssueRd!=0; −1 on drain. Simultaneous increment and decrement leave it unchanged.
  - LLIssueOK = (count<FIFO_DEPTH) && !pending[LLIssueRd]. Because of this bound the FIFO never overflows.
  - LLIssue while LLIssueOK=0 is ignored.
- Scoreboard pending[31:0]:
  - Set bit LLIssueRd on accepted issue (rd!=0).
  - Clear bit head.rd on drain.
  - Same-cycle set and clear of the same bit: set wins.
  - pending[0] is always 0.
- HazardD = pending[Rs1D] | pending[Rs2D] | (RegWriteD & pending[RdD]). This covers RAW and WAW; it is combinational from the current state.
- Starvation FSM, NORMAL/STARVE:
  - Counter increments in each cycle the FIFO is non-empty and pipe_wr=1. It resets to 0 on any drain or when the FIFO is empty.
  - NORMAL→STARVE when the counter reaches STARVE_LIMIT-1 and the head is still blocked.
  - In STARVE, StarveStall=1 (registered).
  - STARVE→NORMAL on the cycle the head drains.
  - A pipeline write that is still in flight during STARVE still wins. The hazard unit guarantees RegWriteW=0 from the cycle after StarveStall rises.
- Latency: LL result to register file is 1 cycle after acceptance at minimum (the push cycle then the drain cycle). Drain order is FIFO order.
- Width: data paths are WIDTH bits, with no extension or truncation.

Decomposition:
- Shared package cpu_pkg:
  - REG_ADDR_W=5.
  - typedef ll_entry_t {rd[4:0], data[WIDTH-1:0]}.
  - enum arb_state_t {NORMAL, STARVE}.
- Natural sub-module: ll_result_fifo. Synchronous FIFO with push/pop/full/empty/head, parameterised by FIFO_DEPTH and ll_entry_t.

Test Plan:
1. Issue LL rd=5, then LLValid rd=5 data=0xDEADBEEF with RegWriteW=0 → next cycle WE3=1, A3=5, WD3=0xDEADBEEF; pending[5] clears; HazardD with Rs1D=5 is 1 before the drain and 0 after.
2. LL result rd=7 pushed while RegWriteW=1 RdW=3 for 6 cycles:
   - every cycle A3=3;
   - StarveStall=1 after 4 blocked cycles;
   - when RegWriteW drops, A3=7 and StarveStall clears the next cycle.
3. Two LL issues, rd=8 then rd=9 → LLIssueOK=0 for a third issue. Results pushed back-to-back → LLReady=0 while full; drained in order 8 then 9.
4. RegWriteW=1 RdW=0 with FIFO head rd=4 → LL write wins: WE3=1, A3=4. LLValid rd=0 → no push, no write.
5. Same-cycle drain of rd=10 and new issue rd=10 → pending[10]=1 afterwards, and HazardD with Rs2D=10 is 1.
6. Assert rst with FIFO full and pending bits set → next cycle WE3=0, LLReady=1, HazardD=0, StarveStall=0; no stale write follows.
